// File: rtl/multicycle_control.sv
// multicycle_control
//   Moore sequencer for the shared multicycle MIPS datapath. The datapath has one
//   ALU, one unified memory and the IR/MDR/ALUOut registers. The sequencer covers
//   the base ISA plus brv, jmxor, nandi, blezal, jalpc and baln. It waits on
//   variable-latency memory through mem_ready and counts retired instructions.
// Ports
//   clk, rst_n            clock; asynchronous active-low reset
//   opcode, funct         IR fields (opcode valid from DECODE on)
//   mem_ready             memory access completes this cycle
//   zero                  ALU result == 0 (consumed by the datapath's beq AND gate)
//   lez, v_flag, n_flag   branch conditions resolved here for blezal/brv/baln
//   pc_write ... pc_source  datapath controls (see per-state decode below)
//   retire                one-cycle pulse when an instruction completes
//   retire_count          wrapping count of retired instructions
//   illegal               sticky undefined-instruction flag
//   state                 current state, for debug
module multicycle_control #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             mem_ready,
  input  logic             zero,
  input  logic             lez,
  input  logic             v_flag,
  input  logic             n_flag,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic [1:0]       reg_dst,
  output logic [1:0]       mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic             retire,
  output logic [CNT_W-1:0] retire_count,
  output logic             illegal,
  output logic [4:0]       state
);

  typedef enum logic [4:0] {
    S_FETCH    = 5'd0,  S_DECODE   = 5'd1,  S_MEM_ADDR = 5'd2,  S_MEM_RD   = 5'd3,
    S_MEM_WB   = 5'd4,  S_MEM_WR   = 5'd5,  S_R_EXEC   = 5'd6,  S_R_WB     = 5'd7,
    S_NANDI_EX = 5'd8,  S_NANDI_WB = 5'd9,  S_BEQ      = 5'd10, S_JUMP     = 5'd11,
    S_BRV      = 5'd12, S_JMX_ADDR = 5'd13, S_JMX_RD   = 5'd14, S_BLEZAL   = 5'd15,
    S_JALPC    = 5'd16, S_BALN     = 5'd17, S_TRAP     = 5'd18
  } state_t;

  state_t     state_q, state_d;
  logic       pcw_c, pcwc_c, iord_c, mrd_c, mwr_c, irw_c, rw_c, sa_c, ret_c;
  logic [1:0] rd_c, m2r_c, sb_c, ps_c;
  logic [2:0] aop_c;

  // zero only feeds the datapath's pc_write_cond gate; beq never branches on it here.
  logic unused_zero;
  assign unused_zero = zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_FETCH;
      retire_count <= '0;
      illegal      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (ret_c)
        retire_count <= retire_count + CNT_W'(1);
      if (state_q == S_TRAP)
        illegal <= 1'b1;
    end
  end

  always_comb begin
    state_d = S_FETCH;
    pcw_c = 1'b0; pcwc_c = 1'b0; iord_c = 1'b0; mrd_c = 1'b0; mwr_c = 1'b0;
    irw_c = 1'b0; rw_c = 1'b0; sa_c = 1'b0; ret_c = 1'b0;
    rd_c = 2'b00; m2r_c = 2'b00; sb_c = 2'b00; ps_c = 2'b00; aop_c = 3'b000;
    case (state_q)
      S_FETCH: begin
        mrd_c = 1'b1;
        sb_c  = 2'b01;
        irw_c = mem_ready;
        pcw_c = mem_ready;
        state_d = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        sb_c = 2'b11;  // branch target precomputed into ALUOut
        case (opcode)
          6'b100011, 6'b101011: state_d = S_MEM_ADDR;
          6'b000000: begin
            if (funct == 6'b010100)      state_d = S_BRV;
            else if (funct == 6'b100011) state_d = S_JMX_ADDR;
            else                         state_d = S_R_EXEC;
          end
          6'b000100: state_d = S_BEQ;
          6'b000010: state_d = S_JUMP;
          6'b010000: state_d = S_NANDI_EX;
          6'b100100: state_d = S_BLEZAL;
          6'b011111: state_d = S_JALPC;
          6'b011011: state_d = S_BALN;
          default:   state_d = S_TRAP;
        endcase
      end
      S_MEM_ADDR: begin
        sa_c = 1'b1; sb_c = 2'b10;
        state_d = (opcode == 6'b100011) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        iord_c = 1'b1; mrd_c = 1'b1;
        state_d = mem_ready ? S_MEM_WB : S_MEM_RD;
      end
      S_MEM_WB: begin
        rw_c = 1'b1; m2r_c = 2'b01; ret_c = 1'b1;
      end
      S_MEM_WR: begin
        iord_c = 1'b1; mwr_c = 1'b1; ret_c = mem_ready;
        state_d = mem_ready ? S_FETCH : S_MEM_WR;
      end
      S_R_EXEC: begin
        sa_c = 1'b1; aop_c = 3'b100; state_d = S_R_WB;
      end
      S_R_WB: begin
        rw_c = 1'b1; rd_c = 2'b01; ret_c = 1'b1;
      end
      S_NANDI_EX: begin
        sa_c = 1'b1; sb_c = 2'b10; aop_c = 3'b011; state_d = S_NANDI_WB;
      end
      S_NANDI_WB: begin
        rw_c = 1'b1; ret_c = 1'b1;
      end
      S_BEQ: begin
        // The datapath ANDs pc_write_cond with zero, so the not-taken case still retires.
        sa_c = 1'b1; aop_c = 3'b001; pcwc_c = 1'b1; ps_c = 2'b01; ret_c = 1'b1;
      end
      S_JUMP: begin
        pcw_c = 1'b1; ps_c = 2'b10; ret_c = 1'b1;
      end
      S_BRV: begin
        // pc_source 11 with iord=0 selects rs.
        sa_c = 1'b1; ps_c = 2'b11; pcw_c = v_flag; ret_c = 1'b1;
      end
      S_BLEZAL, S_BALN: begin
        // Link and branch share the same condition; muxes stay steered when not taken.
        sa_c = 1'b1; rd_c = 2'b10; m2r_c = 2'b10; ps_c = 2'b01; ret_c = 1'b1;
        pcw_c = (state_q == S_BLEZAL) ? lez : n_flag;
        rw_c  = (state_q == S_BLEZAL) ? lez : n_flag;
      end
      S_JALPC: begin
        sa_c = 1'b1; rw_c = 1'b1; m2r_c = 2'b10; pcw_c = 1'b1; ps_c = 2'b11; ret_c = 1'b1;
      end
      S_JMX_ADDR: begin
        sa_c = 1'b1; aop_c = 3'b110; state_d = S_JMX_RD;
      end
      S_JMX_RD: begin
        // pc_source 11 with iord=1 selects MDR; PC and $31 update only once data returns.
        iord_c = 1'b1; mrd_c = 1'b1; ps_c = 2'b11; rd_c = 2'b10; m2r_c = 2'b10;
        pcw_c = mem_ready; rw_c = mem_ready; ret_c = mem_ready;
        state_d = mem_ready ? S_FETCH : S_JMX_RD;
      end
      S_TRAP:  state_d = S_FETCH;
      default: state_d = S_FETCH;
    endcase
  end

  // Every control is held low while reset is asserted, even though FETCH would request memory.
  always_comb begin
    pc_write      = rst_n & pcw_c;
    pc_write_cond = rst_n & pcwc_c;
    iord          = rst_n & iord_c;
    mem_read      = rst_n & mrd_c;
    mem_write     = rst_n & mwr_c;
    ir_write      = rst_n & irw_c;
    reg_write     = rst_n & rw_c;
    reg_dst       = rst_n ? rd_c  : 2'b00;
    mem_to_reg    = rst_n ? m2r_c : 2'b00;
    alu_src_a     = rst_n & sa_c;
    alu_src_b     = rst_n ? sb_c  : 2'b00;
    alu_op        = rst_n ? aop_c : 3'b000;
    pc_source     = rst_n ? ps_c  : 2'b00;
    retire        = rst_n & ret_c;
  end

  assign state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

  localparam int S_FETCH = 0, S_DECODE = 1, S_MEM_ADDR = 2, S_MEM_RD = 3, S_MEM_WB = 4,
                 S_MEM_WR = 5, S_R_EXEC = 6, S_R_WB = 7, S_NANDI_EX = 8, S_NANDI_WB = 9,
                 S_BEQ = 10, S_JUMP = 11, S_BRV = 12, S_JMX_ADDR = 13, S_JMX_RD = 14,
                 S_BLEZAL = 15, S_JALPC = 16, S_BALN = 17, S_TRAP = 18;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  opcode = '0, funct = '0;
  logic        mem_ready = 1'b0, zero = 1'b0, lez = 1'b0, v_flag = 1'b0, n_flag = 1'b0;
  logic        pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, reg_write;
  logic [1:0]  reg_dst, mem_to_reg, alu_src_b, pc_source;
  logic        alu_src_a, retire, illegal;
  logic [2:0]  alu_op;
  logic [15:0] retire_count;
  logic [4:0]  state;
  logic [2:0]  w_count;
  wire  [25:0] w_unused_bus;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .zero(zero), .lez(lez), .v_flag(v_flag), .n_flag(n_flag),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .retire(retire), .retire_count(retire_count), .illegal(illegal),
    .state(state)
  );

  // Narrow-counter instance sharing the same stimulus, so counter wrap is reachable quickly.
  multicycle_control #(.CNT_W(3)) dut_w (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .zero(zero), .lez(lez), .v_flag(v_flag), .n_flag(n_flag),
    .pc_write(w_unused_bus[0]), .pc_write_cond(w_unused_bus[1]), .iord(w_unused_bus[2]),
    .mem_read(w_unused_bus[3]), .mem_write(w_unused_bus[4]), .ir_write(w_unused_bus[5]),
    .reg_write(w_unused_bus[6]), .reg_dst(w_unused_bus[8:7]), .mem_to_reg(w_unused_bus[10:9]),
    .alu_src_a(w_unused_bus[11]), .alu_src_b(w_unused_bus[13:12]), .alu_op(w_unused_bus[16:14]),
    .pc_source(w_unused_bus[18:17]), .retire(w_unused_bus[19]), .retire_count(w_count),
    .illegal(w_unused_bus[20]), .state(w_unused_bus[25:21])
  );

  typedef struct packed {
    logic [4:0]  st;
    logic [20:0] ctl;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [15:0] exp_cnt = '0;
  logic        exp_ill = 1'b0;

  // Control word: {pcw,pcwc,iord,mrd,mwr,irw,rw,reg_dst,mem_to_reg,src_a,src_b,alu_op,pc_source,retire,illegal}
  function automatic logic [20:0] mk(input logic pcw, pcwc, io, mrd, mwr, irw, rw,
                                     input logic [1:0] rd, m2r, input logic sa,
                                     input logic [1:0] sb, input logic [2:0] aop,
                                     input logic [1:0] ps, input logic ret);
    return {pcw, pcwc, io, mrd, mwr, irw, rw, rd, m2r, sa, sb, aop, ps, ret, 1'b0};
  endfunction

  localparam logic [20:0] C_NONE      = 21'd0;
  logic [20:0] C_FETCH_WAIT, C_FETCH_GO, C_DECODE, C_MEM_ADDR, C_MEM_RD, C_MEM_WB, C_MEM_WR_WAIT,
               C_MEM_WR_DONE, C_R_EXEC, C_R_WB, C_NANDI_EX, C_NANDI_WB, C_BEQ, C_JUMP,
               C_BRV_T, C_BRV_N, C_LINK_T, C_LINK_N, C_JALPC, C_JMX_ADDR, C_JMX_RD;

  initial begin
    C_FETCH_WAIT  = mk(0,0,0,1,0,0,0,2'd0,2'd0,0,2'd1,3'd0,2'd0,0);
    C_FETCH_GO    = mk(1,0,0,1,0,1,0,2'd0,2'd0,0,2'd1,3'd0,2'd0,0);
    C_DECODE      = mk(0,0,0,0,0,0,0,2'd0,2'd0,0,2'd3,3'd0,2'd0,0);
    C_MEM_ADDR    = mk(0,0,0,0,0,0,0,2'd0,2'd0,1,2'd2,3'd0,2'd0,0);
    C_MEM_RD      = mk(0,0,1,1,0,0,0,2'd0,2'd0,0,2'd0,3'd0,2'd0,0);
    C_MEM_WB      = mk(0,0,0,0,0,0,1,2'd0,2'd1,0,2'd0,3'd0,2'd0,1);
    C_MEM_WR_WAIT = mk(0,0,1,0,1,0,0,2'd0,2'd0,0,2'd0,3'd0,2'd0,0);
    C_MEM_WR_DONE = mk(0,0,1,0,1,0,0,2'd0,2'd0,0,2'd0,3'd0,2'd0,1);
    C_R_EXEC      = mk(0,0,0,0,0,0,0,2'd0,2'd0,1,2'd0,3'd4,2'd0,0);
    C_R_WB        = mk(0,0,0,0,0,0,1,2'd1,2'd0,0,2'd0,3'd0,2'd0,1);
    C_NANDI_EX    = mk(0,0,0,0,0,0,0,2'd0,2'd0,1,2'd2,3'd3,2'd0,0);
    C_NANDI_WB    = mk(0,0,0,0,0,0,1,2'd0,2'd0,0,2'd0,3'd0,2'd0,1);
    C_BEQ         = mk(0,1,0,0,0,0,0,2'd0,2'd0,1,2'd0,3'd1,2'd1,1);
    C_JUMP        = mk(1,0,0,0,0,0,0,2'd0,2'd0,0,2'd0,3'd0,2'd2,1);
    C_BRV_T       = mk(1,0,0,0,0,0,0,2'd0,2'd0,1,2'd0,3'd0,2'd3,1);
    C_BRV_N       = mk(0,0,0,0,0,0,0,2'd0,2'd0,1,2'd0,3'd0,2'd3,1);
    C_LINK_T      = mk(1,0,0,0,0,0,1,2'd2,2'd2,1,2'd0,3'd0,2'd1,1);
    C_LINK_N      = mk(0,0,0,0,0,0,0,2'd2,2'd2,1,2'd0,3'd0,2'd1,1);
    C_JALPC       = mk(1,0,0,0,0,0,1,2'd0,2'd2,1,2'd0,3'd0,2'd3,1);
    C_JMX_ADDR    = mk(0,0,0,0,0,0,0,2'd0,2'd0,1,2'd0,3'd6,2'd0,0);
    C_JMX_RD      = mk(1,0,1,1,0,0,1,2'd2,2'd2,0,2'd0,3'd0,2'd3,1);
  end

  // Drive one cycle of inputs just after the rising edge and queue what that cycle must show.
  // flags = {zero, lez, v_flag, n_flag}
  task automatic step(input logic rn, input logic [5:0] op, input logic [5:0] fn,
                      input logic mr, input logic [3:0] flags, input int es,
                      input logic [20:0] ec);
    exp_t e;
    @(posedge clk); #1;
    rst_n = rn; opcode = op; funct = fn; mem_ready = mr;
    {zero, lez, v_flag, n_flag} = flags;
    if (!rn) begin
      exp_cnt = '0;
      exp_ill = 1'b0;
    end
    e.st  = 5'(es);
    e.ctl = ec | {20'd0, exp_ill};
    e.cnt = exp_cnt;
    sb_q.push_back(e);
    if (ec[1]) exp_cnt = exp_cnt + 16'd1;
    if (es == S_TRAP) exp_ill = 1'b1;
  endtask

  task automatic fetch_dec(input logic [5:0] op, input logic [5:0] fn);
    step(1, op, fn, 1, 4'b0000, S_FETCH, C_FETCH_GO);
    step(1, op, fn, 1, 4'b0000, S_DECODE, C_DECODE);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
    end
  endtask

  // Monitor: the DUT presents a full control word every cycle; compare mid-cycle.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      chk("state", 32'(state), 32'(e.st));
      chk("ctrl", 32'({pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, reg_write,
                       reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source, retire,
                       illegal}), 32'(e.ctl));
      chk("retire_count", 32'(retire_count), 32'(e.cnt));
      chk("retire_count_w3", 32'(w_count), 32'(e.cnt[2:0]));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // reset state
    step(0, 6'd0, 6'd0, 0, 4'b0000, S_FETCH, C_NONE);
    step(0, 6'd0, 6'd0, 1, 4'b0000, S_FETCH, C_NONE);
    // lw with two FETCH stalls and one MEM_RD stall
    step(1, 6'b100011, 6'd0, 0, 4'b0000, S_FETCH, C_FETCH_WAIT);
    step(1, 6'b100011, 6'd0, 0, 4'b0000, S_FETCH, C_FETCH_WAIT);
    step(1, 6'b100011, 6'd0, 1, 4'b0000, S_FETCH, C_FETCH_GO);
    step(1, 6'b100011, 6'd0, 1, 4'b0000, S_DECODE, C_DECODE);
    step(1, 6'b100011, 6'd0, 0, 4'b0000, S_MEM_ADDR, C_MEM_ADDR);
    step(1, 6'b100011, 6'd0, 0, 4'b0000, S_MEM_RD, C_MEM_RD);
    step(1, 6'b100011, 6'd0, 1, 4'b0000, S_MEM_RD, C_MEM_RD);
    step(1, 6'b100011, 6'd0, 1, 4'b0000, S_MEM_WB, C_MEM_WB);
    // beq not taken, then taken
    fetch_dec(6'b000100, 6'd0);
    step(1, 6'b000100, 6'd0, 1, 4'b0000, S_BEQ, C_BEQ);
    fetch_dec(6'b000100, 6'd0);
    step(1, 6'b000100, 6'd0, 1, 4'b1000, S_BEQ, C_BEQ);
    // blezal taken, then not taken
    fetch_dec(6'b100100, 6'd0);
    step(1, 6'b100100, 6'd0, 1, 4'b0100, S_BLEZAL, C_LINK_T);
    fetch_dec(6'b100100, 6'd0);
    step(1, 6'b100100, 6'd0, 1, 4'b0000, S_BLEZAL, C_LINK_N);
    // jmxor
    fetch_dec(6'b000000, 6'b100011);
    step(1, 6'b000000, 6'b100011, 1, 4'b0000, S_JMX_ADDR, C_JMX_ADDR);
    step(1, 6'b000000, 6'b100011, 1, 4'b0000, S_JMX_RD, C_JMX_RD);
    // R-type add
    fetch_dec(6'b000000, 6'b100000);
    step(1, 6'b000000, 6'b100000, 1, 4'b0000, S_R_EXEC, C_R_EXEC);
    step(1, 6'b000000, 6'b100000, 1, 4'b0000, S_R_WB, C_R_WB);
    // nandi
    fetch_dec(6'b010000, 6'd0);
    step(1, 6'b010000, 6'd0, 1, 4'b0000, S_NANDI_EX, C_NANDI_EX);
    step(1, 6'b010000, 6'd0, 1, 4'b0000, S_NANDI_WB, C_NANDI_WB);
    // brv taken, then not taken
    fetch_dec(6'b000000, 6'b010100);
    step(1, 6'b000000, 6'b010100, 1, 4'b0010, S_BRV, C_BRV_T);
    fetch_dec(6'b000000, 6'b010100);
    step(1, 6'b000000, 6'b010100, 1, 4'b0000, S_BRV, C_BRV_N);
    // undefined opcode: trap, no retire, illegal sticks afterwards
    fetch_dec(6'b111111, 6'd0);
    step(1, 6'b111111, 6'd0, 1, 4'b0000, S_TRAP, C_NONE);
    // jalpc
    fetch_dec(6'b011111, 6'd0);
    step(1, 6'b011111, 6'd0, 1, 4'b0000, S_JALPC, C_JALPC);
    // baln not taken, then taken
    fetch_dec(6'b011011, 6'd0);
    step(1, 6'b011011, 6'd0, 1, 4'b0000, S_BALN, C_LINK_N);
    fetch_dec(6'b011011, 6'd0);
    step(1, 6'b011011, 6'd0, 1, 4'b0001, S_BALN, C_LINK_T);
    // sw completing normally
    fetch_dec(6'b101011, 6'd0);
    step(1, 6'b101011, 6'd0, 1, 4'b0000, S_MEM_ADDR, C_MEM_ADDR);
    step(1, 6'b101011, 6'd0, 1, 4'b0000, S_MEM_WR, C_MEM_WR_DONE);
    // sw interrupted by reset while waiting in MEM_WR
    fetch_dec(6'b101011, 6'd0);
    step(1, 6'b101011, 6'd0, 0, 4'b0000, S_MEM_ADDR, C_MEM_ADDR);
    step(1, 6'b101011, 6'd0, 0, 4'b0000, S_MEM_WR, C_MEM_WR_WAIT);
    step(0, 6'b101011, 6'd0, 1, 4'b0000, S_FETCH, C_NONE);
    step(0, 6'b101011, 6'd0, 1, 4'b0000, S_FETCH, C_NONE);
    // ten jumps: the 3-bit counter wraps through zero
    for (int i = 0; i < 10; i++) begin
      fetch_dec(6'b000010, 6'd0);
      step(1, 6'b000010, 6'd0, 1, 4'b0000, S_JUMP, C_JUMP);
    end
    step(1, 6'b000010, 6'd0, 0, 4'b0000, S_FETCH, C_FETCH_WAIT);
    @(negedge clk); #1;
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
